// File: rtl/rr_req_agent_if.sv
// Handshake bundle between one requester agent and its client, arbiter port and shared bus.
// master is the agent's view; slave is the environment (client, arbiter and bus) view.
interface rr_req_agent_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              req;
    logic              gnt;
    logic              eot;

    logic              bus_valid;
    logic              bus_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_last;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, gnt, bus_ready,
        output cmd_ready, req, eot, bus_valid, bus_addr, bus_last
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, gnt, bus_ready,
        input  cmd_ready, req, eot, bus_valid, bus_addr, bus_last
    );
endinterface

// File: rtl/rr_req_agent.sv
// Requester front-end for one port of the round-robin arbiter: queues burst commands,
// requests the bus, issues len+1 address beats, then hands ownership back with eot.
module rr_req_agent #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rstn,
    rr_req_agent_if.master agent,
    output logic           busy,
    output logic           proto_err
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_EOT  = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [LEN_W-1:0]  fifo_len  [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  beat_cnt;
    logic [1:0]        drop_cnt;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push       = agent.cmd_valid & ~fifo_full;
    assign pop        = (state == S_REQ) & agent.gnt;

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= agent.cmd_addr;
            fifo_len[wr_ptr[PTR_W-1:0]]  <= agent.cmd_len;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            cur_len   <= '0;
            beat_cnt  <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (agent.gnt) proto_err <= 1'b1;
                    if (!fifo_empty) state <= S_REQ;
                end
                S_REQ: begin
                    if (agent.gnt) begin
                        cur_addr <= fifo_addr[rd_ptr[PTR_W-1:0]];
                        cur_len  <= fifo_len[rd_ptr[PTR_W-1:0]];
                        beat_cnt <= '0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    // A grant lost mid-burst freezes the current beat until it returns.
                    if (!agent.gnt) begin
                        proto_err <= 1'b1;
                    end else if (agent.bus_ready) begin
                        if (beat_cnt == cur_len) state <= S_EOT;
                        else                     beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_EOT: begin
                    drop_cnt <= '0;
                    state    <= S_DROP;
                end
                S_DROP: begin
                    if (!agent.gnt)             state     <= S_IDLE;
                    else if (drop_cnt == 2'd2)  proto_err <= 1'b1;
                    else                        drop_cnt  <= drop_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign agent.cmd_ready = ~fifo_full;
    assign agent.req       = (state == S_REQ) | (state == S_XFER);
    assign agent.eot       = (state == S_EOT);
    assign agent.bus_valid = (state == S_XFER) & agent.gnt;
    assign agent.bus_addr  = cur_addr + ADDR_W'(beat_cnt);
    assign agent.bus_last  = (state == S_XFER) & (beat_cnt == cur_len);
    assign busy            = (state != S_IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_rr_req_agent.sv
// Four requester agents around a registered round-robin arbiter model; agent 0 is
// checked beat by beat against a scoreboard filled as commands are pushed.
module tb_rr_req_agent;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 4;
    localparam int N      = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [N-1:0]      cmd_valid, cmd_ready, req, gnt, eot;
    logic [N-1:0]      bus_valid, bus_ready, bus_last, busy, proto_err;
    logic [ADDR_W-1:0] cmd_addr [N];
    logic [LEN_W-1:0]  cmd_len  [N];
    logic [ADDR_W-1:0] bus_addr [N];
    logic [N-1:0]      arb_gnt, force_en, force_val;

    assign gnt = (force_en & force_val) | (~force_en & arb_gnt);

    for (genvar g = 0; g < N; g++) begin : g_agent
        rr_req_agent_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_if ();
        assign bus_if.cmd_valid = cmd_valid[g];
        assign bus_if.cmd_addr  = cmd_addr[g];
        assign bus_if.cmd_len   = cmd_len[g];
        assign bus_if.gnt       = gnt[g];
        assign bus_if.bus_ready = bus_ready[g];
        assign cmd_ready[g]     = bus_if.cmd_ready;
        assign req[g]           = bus_if.req;
        assign eot[g]           = bus_if.eot;
        assign bus_valid[g]     = bus_if.bus_valid;
        assign bus_addr[g]      = bus_if.bus_addr;
        assign bus_last[g]      = bus_if.bus_last;

        rr_req_agent #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
            .clk       (clk),
            .rstn      (rstn),
            .agent     (bus_if.master),
            .busy      (busy[g]),
            .proto_err (proto_err[g])
        );
    end

    // Registered round-robin arbiter: grants one cycle after req, drops one cycle after eot.
    logic [1:0] last_idx, owner;
    logic       owned;
    int         pick;
    int         grant_log[$];

    function automatic int rr_pick(input logic [N-1:0] r, input logic [1:0] last);
        for (int k = 1; k <= N; k++) begin
            logic [1:0] c;
            c = last + 2'(k);
            if (r[c]) return int'(c);
        end
        return -1;
    endfunction

    always_comb pick = rr_pick(req, last_idx);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arb_gnt  <= '0;
            owned    <= 1'b0;
            owner    <= '0;
            last_idx <= 2'd3;
        end else if (owned) begin
            if (eot[owner]) begin
                arb_gnt <= '0;
                owned   <= 1'b0;
            end
        end else if (pick >= 0) begin
            arb_gnt  <= 4'(1) << pick;
            owned    <= 1'b1;
            owner    <= 2'(pick);
            last_idx <= 2'(pick);
            grant_log.push_back(pick);
        end
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    eot_cnt [N];
    int    hs_cnt  [N];
    int    hs_cyc_q[$];
    int    eot_cyc = 0;
    int    last_push_cyc = 0;
    beat_t exp_q[$];
    beat_t exp_b;
    logic  req0_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor for agent 0, plus eot/handshake counters for every agent.
    always @(negedge clk) begin
        if (!rstn) begin
            req0_q = 1'b0;
        end else begin
            for (int g = 0; g < N; g++) begin
                if (eot[g]) eot_cnt[g]++;
                if (bus_valid[g] && bus_ready[g]) hs_cnt[g]++;
            end
            if (eot[0]) begin
                eot_cyc = cyc;
                check("eot_req_low", 32'(req[0]), 32'd0);
                check("eot_valid_low", 32'(bus_valid[0]), 32'd0);
            end
            if (req[0] && !req0_q) check("rereq_gnt_low", 32'(gnt[0]), 32'd0);
            if (bus_valid[0] && bus_ready[0]) begin
                hs_cyc_q.push_back(cyc);
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_beat: observed addr 0x%0h expected no beat", bus_addr[0]);
                end
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("beat_addr", 32'(bus_addr[0]), 32'(exp_b.addr));
                    check("beat_last", 32'(bus_last[0]), 32'(exp_b.last));
                end
            end
            req0_q = req[0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sb_push(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        beat_t b;
        for (int i = 0; i <= int'(len); i++) begin
            b.addr = addr + ADDR_W'(i);
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    task automatic push_cmd(input int a, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        int n = 0;
        cmd_addr[a]  = addr;
        cmd_len[a]   = len;
        cmd_valid[a] = 1'b1;
        while (!cmd_ready[a] && n < 100) begin
            tick();
            n++;
        end
        check("push_accepted", 32'(cmd_ready[a]), 32'd1);
        if (cmd_ready[a]) begin
            if (a == 0) sb_push(addr, len);
            tick();
            last_push_cyc = cyc;
        end
        cmd_valid[a] = 1'b0;
    endtask

    function automatic logic flag(input int sel);
        case (sel)
            0:       return req[0];
            1:       return bus_valid[0];
            default: return eot[0];
        endcase
    endfunction

    task automatic wait_flag(input int sel, input string tag);
        int n = 0;
        while (!flag(sel) && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(flag(sel)), 32'd1);
    endtask

    task automatic wait_all_idle(input string tag, input int budget);
        int n = 0;
        while ((busy != '0 || gnt != '0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    int base_hs, base_eot;

    initial begin
        rstn      = 1'b0;
        cmd_valid = '0;
        bus_ready = '1;
        force_en  = '0;
        force_val = '0;
        for (int i = 0; i < N; i++) begin
            cmd_addr[i] = '0;
            cmd_len[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        check("rst_req", 32'(req[0]), 32'd0);
        check("rst_eot", 32'(eot[0]), 32'd0);
        check("rst_bus_valid", 32'(bus_valid[0]), 32'd0);
        check("rst_bus_last", 32'(bus_last[0]), 32'd0);
        check("rst_bus_addr", 32'(bus_addr[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_proto_err", 32'(proto_err[0]), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
        rstn = 1'b1;
        tick();

        // Four agents, one len=0 command each, all requesting together.
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            cmd_addr[i] = 16'h1000 + 16'(i * 16'h0100);
            cmd_len[i]  = '0;
        end
        cmd_valid = '1;
        sb_push(16'h1000, 4'd0);
        tick();
        cmd_valid = '0;
        wait_all_idle("four_agents", 200);
        check("grant_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < N; k++) begin
            check("grant_order", (grant_log.size() > k) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(k));
            check("agent_eot_once", 32'(eot_cnt[k]), 32'd1);
            check("agent_one_beat", 32'(hs_cnt[k]), 32'd1);
            check("agent_no_proto_err", 32'(proto_err[k]), 32'd0);
        end

        // Single burst, 0x0100 len 3.
        hs_cyc_q.delete();
        base_hs = hs_cnt[0];
        push_cmd(0, 16'h0100, 4'd3);
        @(negedge clk);
        check("req_push_plus1", 32'(req[0]), 32'd0);
        @(negedge clk);
        check("req_push_plus2", 32'(req[0]), 32'd1);
        wait_all_idle("single", 100);
        check("single_beats", 32'(hs_cnt[0] - base_hs), 32'd4);
        check("single_hs_cycles", 32'(hs_cyc_q.size()), 32'd4);
        if (hs_cyc_q.size() == 4) begin
            check("single_first_latency", 32'(hs_cyc_q[0] - last_push_cyc), 32'd3);
            check("single_consecutive", 32'(hs_cyc_q[3] - hs_cyc_q[0]), 32'd3);
            check("single_eot_after_last", 32'(eot_cyc), 32'(hs_cyc_q[3] + 1));
        end

        // Backpressure, len 2, bus_ready 1,0,0,1,1.
        hs_cyc_q.delete();
        base_hs = hs_cnt[0];
        push_cmd(0, 16'h0200, 4'd2);
        wait_flag(1, "bp_valid");
        tick();
        bus_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_stall_addr", 32'(bus_addr[0]), 32'h0201);
        check("bp_stall_valid", 32'(bus_valid[0]), 32'd1);
        tick();
        @(negedge clk);
        check("bp_stall_addr2", 32'(bus_addr[0]), 32'h0201);
        check("bp_stall_last", 32'(bus_last[0]), 32'd0);
        tick();
        bus_ready[0] = 1'b1;
        wait_all_idle("backpressure", 100);
        check("bp_handshakes", 32'(hs_cnt[0] - base_hs), 32'd3);
        if (hs_cyc_q.size() == 3) begin
            check("bp_gap", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd3);
            check("bp_eot_after_third", 32'(eot_cyc), 32'(hs_cyc_q[2] + 1));
        end

        // FIFO fill with grant withheld, then drain in order.
        base_hs  = hs_cnt[0];
        base_eot = eot_cnt[0];
        force_en[0]  = 1'b1;
        force_val[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 16'h2000 + 16'(i * 16'h0100), 4'(i % 2));
            check("fifo_cmd_ready", 32'(cmd_ready[0]), 32'(i < 3));
        end
        check("fifo_req_waiting", 32'(req[0]), 32'd1);
        force_en[0] = 1'b0;
        push_cmd(0, 16'h2400, 4'd0);
        wait_all_idle("fifo_drain", 300);
        check("fifo_beats", 32'(hs_cnt[0] - base_hs), 32'd7);
        check("fifo_eots", 32'(eot_cnt[0] - base_eot), 32'd5);

        // Address wrap.
        base_hs = hs_cnt[0];
        push_cmd(0, 16'hFFFE, 4'd3);
        wait_all_idle("wrap", 100);
        check("wrap_beats", 32'(hs_cnt[0] - base_hs), 32'd4);
        check("clean_proto_err", 32'(proto_err[0]), 32'd0);

        // Grant withdrawn mid-burst.
        base_hs = hs_cnt[0];
        push_cmd(0, 16'h3000, 4'd3);
        wait_flag(1, "drop_valid");
        tick();
        force_en[0]  = 1'b1;
        force_val[0] = 1'b0;
        @(negedge clk);
        check("gnt_lost_valid", 32'(bus_valid[0]), 32'd0);
        tick();
        @(negedge clk);
        check("gnt_lost_proto_err", 32'(proto_err[0]), 32'd1);
        check("gnt_lost_addr_held", 32'(bus_addr[0]), 32'h3001);
        tick();
        force_en[0] = 1'b0;
        wait_all_idle("gnt_lost", 100);
        check("gnt_lost_beats", 32'(hs_cnt[0] - base_hs), 32'd4);

        // Reset during beat 2 of a len=7 burst with a second command queued.
        push_cmd(0, 16'h4000, 4'd7);
        push_cmd(0, 16'h5000, 4'd0);
        wait_flag(1, "rst_burst_valid");
        tick();
        tick();
        check("rst_burst_beat2", 32'(bus_addr[0]), 32'h4002);
        base_eot = eot_cnt[0];
        #1 rstn = 1'b0;
        #1;
        check("async_rst_req", 32'(req[0]), 32'd0);
        check("async_rst_valid", 32'(bus_valid[0]), 32'd0);
        check("async_rst_addr", 32'(bus_addr[0]), 32'd0);
        check("async_rst_busy", 32'(busy[0]), 32'd0);
        check("async_rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
        check("async_rst_proto_err", 32'(proto_err[0]), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        check("rst_no_eot", 32'(eot_cnt[0] - base_eot), 32'd0);
        check("rst_queue_discarded", 32'(busy[0]), 32'd0);
        base_hs = hs_cnt[0];
        push_cmd(0, 16'h6000, 4'd1);
        wait_all_idle("post_reset", 100);
        check("post_reset_beats", 32'(hs_cnt[0] - base_hs), 32'd2);

        // Stray grant while idle.
        force_en[0]  = 1'b1;
        force_val[0] = 1'b1;
        tick();
        force_en[0] = 1'b0;
        @(negedge clk);
        check("idle_gnt_proto_err", 32'(proto_err[0]), 32'd1);
        check("idle_gnt_ignored", 32'(busy[0]), 32'd0);

        // Grant held through DROP: tolerated for two cycles, flagged on the third.
        #1 rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        push_cmd(0, 16'h7000, 4'd0);
        wait_flag(2, "drop_eot");
        force_en[0]  = 1'b1;
        force_val[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("drop_two_cycles_ok", 32'(proto_err[0]), 32'd0);
        check("drop_still_waiting", 32'(busy[0]), 32'd1);
        @(negedge clk);
        check("drop_third_cycle_err", 32'(proto_err[0]), 32'd1);
        check("drop_req_low", 32'(req[0]), 32'd0);
        tick();
        force_en[0] = 1'b0;
        wait_all_idle("drop_release", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
